// File: rtl/lidar_packet_framer.sv
// Serial LiDAR packet framer: hunts the oversampled bit stream for a header, collects one
// fixed-length packet, and hands it over through a one-deep valid/ready buffer.
module lidar_packet_framer #(
    parameter int          PKT_BYTES    = 47,
    parameter logic [15:0] HEADER       = 16'h542C,
    parameter int          TIMEOUT_CLKS = 1000,
    parameter int          CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   bit_tick,
    input  logic                   data_in,
    output logic [PKT_BYTES*8-1:0] pkt_data,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic                   hdr_seen,
    output logic                   frame_err,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int PKT_BITS  = PKT_BYTES * 8;
    localparam int BIT_CNT_W = $clog2(PKT_BITS - 16);
    localparam int GAP_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(PKT_BITS - 17);
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_t;

    state_t                state, state_nxt;
    logic [PKT_BITS-1:0]   sr;
    logic [PKT_BITS-1:0]   sr_shift;
    logic [15:0]           win;
    logic [4:0]            hunt_cnt, hunt_cnt_nxt;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
    logic                  hdr_match;
    logic                  pkt_done;
    logic                  timeout_hit;
    logic                  buf_free;

    assign sr_shift = {sr[PKT_BITS-2:0], data_in};
    assign win      = sr_shift[15:0];
    assign buf_free = !pkt_valid || pkt_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt    = state;
        hunt_cnt_nxt = hunt_cnt;
        bit_cnt_nxt  = bit_cnt;
        gap_cnt_nxt  = gap_cnt;
        hdr_match    = 1'b0;
        pkt_done     = 1'b0;
        timeout_hit  = 1'b0;

        case (state)
            HUNT: begin
                gap_cnt_nxt = '0;
                if (bit_tick) begin
                    // The 16-tick guard keeps a stale packet tail out of the header window.
                    if ((hunt_cnt >= 5'd15) && (win == HEADER)) begin
                        hdr_match   = 1'b1;
                        state_nxt   = COLLECT;
                        bit_cnt_nxt = '0;
                    end else if (hunt_cnt != 5'd16) begin
                        hunt_cnt_nxt = hunt_cnt + 5'd1;
                    end
                end
            end
            COLLECT: begin
                if (bit_tick) begin
                    gap_cnt_nxt = '0;
                    if (bit_cnt == LAST_BIT) begin
                        pkt_done     = 1'b1;
                        state_nxt    = HUNT;
                        hunt_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else if (TIMEOUT_CLKS != 0) begin
                    // Abort on the TIMEOUT_CLKS-th consecutive clock without a tick.
                    if (gap_cnt == GAP_LAST) begin
                        timeout_hit  = 1'b1;
                        state_nxt    = HUNT;
                        hunt_cnt_nxt = '0;
                        gap_cnt_nxt  = '0;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt    = HUNT;
                hunt_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= HUNT;
            hunt_cnt <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state    <= state_nxt;
            hunt_cnt <= hunt_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sr and pkt_data are plain registers with observable contents, so they are reset.
            sr        <= '0;
            pkt_data  <= '0;
            pkt_valid <= 1'b0;
            hdr_seen  <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (bit_tick) begin
                sr <= sr_shift;
            end
            hdr_seen  <= hdr_match;
            frame_err <= timeout_hit;

            if (pkt_done && buf_free) begin
                pkt_data  <= sr_shift;
                pkt_valid <= 1'b1;
            end else if (pkt_done) begin
                if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end else if (pkt_valid && pkt_ready) begin
                pkt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lidar_packet_framer.sv
// Randomised bench for lidar_packet_framer: bit-queue reference model checked every clock,
// plus directed checks for latency, backpressure, timeout and mid-packet reset.
module tb_lidar_packet_framer;

    localparam int          PKT_BYTES = 47;
    localparam int          PKT_BITS  = PKT_BYTES * 8;
    localparam logic [15:0] HEADER    = 16'h542C;
    localparam int          TIMEOUT   = 1000;
    localparam int          CNT_W     = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                bit_tick;
    logic                data_in;
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_valid;
    logic                pkt_ready;
    logic                hdr_seen;
    logic                frame_err;
    logic [CNT_W-1:0]    drop_cnt;

    lidar_packet_framer #(
        .PKT_BYTES   (PKT_BYTES),
        .HEADER      (HEADER),
        .TIMEOUT_CLKS(TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bit_tick (bit_tick),
        .data_in  (data_in),
        .pkt_data (pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .hdr_seen (hdr_seen),
        .frame_err(frame_err),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int dut_hdr_pulses = 0;
    int dut_err_pulses = 0;
    bit rand_ready = 1'b0;

    // Reference model: bits since hunting began, bits of the frame being collected, idle clocks.
    bit                  m_collecting;
    bit                  hunt_q[$];
    bit                  frame_q[$];
    int                  m_idle;
    logic [PKT_BITS-1:0] m_data;
    bit                  m_valid;
    int                  m_drop;
    bit                  m_hdr;
    bit                  m_ferr;

    task automatic check(input string tag, input logic [PKT_BITS-1:0] got, input logic [PKT_BITS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_collecting = 1'b0;
        hunt_q.delete();
        frame_q.delete();
        m_idle  = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_drop  = 0;
        m_hdr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_clock(input bit tick, input bit din, input bit ready);
        bit                  done;
        logic [15:0]         w;
        logic [PKT_BITS-1:0] pkt;
        done   = 1'b0;
        pkt    = '0;
        m_hdr  = 1'b0;
        m_ferr = 1'b0;
        if (tick && !m_collecting) begin
            hunt_q.push_back(din);
            if (hunt_q.size() > 16) void'(hunt_q.pop_front());
            if (hunt_q.size() == 16) begin
                for (int i = 0; i < 16; i++) w[15-i] = hunt_q[i];
                if (w == HEADER) begin
                    m_collecting = 1'b1;
                    m_hdr        = 1'b1;
                    m_idle       = 0;
                    frame_q.delete();
                    for (int i = 15; i >= 0; i--) frame_q.push_back(HEADER[i]);
                end
            end
        end else if (tick) begin
            frame_q.push_back(din);
            m_idle = 0;
            if (frame_q.size() == PKT_BITS) begin
                for (int i = 0; i < PKT_BITS; i++) pkt[PKT_BITS-1-i] = frame_q[i];
                done         = 1'b1;
                m_collecting = 1'b0;
                hunt_q.delete();
            end
        end else if (m_collecting) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_ferr       = 1'b1;
                m_collecting = 1'b0;
                hunt_q.delete();
            end
        end

        if (done && (!m_valid || ready)) begin
            m_data  = pkt;
            m_valid = 1'b1;
        end else if (done) begin
            if (m_drop < (1 << CNT_W) - 1) m_drop++;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs, advance DUT and model together, compare #1 after the edge.
    task automatic cycle(input bit tick, input bit din);
        if (rand_ready) pkt_ready = 1'($urandom_range(1, 0));
        bit_tick = tick;
        data_in  = din;
        @(posedge clk);
        model_clock(tick, din, pkt_ready);
        #1;
        if (hdr_seen === 1'b1) dut_hdr_pulses++;
        if (frame_err === 1'b1) dut_err_pulses++;
        check("pkt_valid", pkt_valid, m_valid);
        check("pkt_data", pkt_data, m_data);
        check("hdr_seen", hdr_seen, m_hdr);
        check("frame_err", frame_err, m_ferr);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic send_bit(input bit b, input int spacing);
        cycle(1'b1, b);
        repeat (spacing - 1) cycle(1'b0, 1'($urandom_range(1, 0)));
    endtask

    // Sends a whole packet; returns right after the final tick's edge so latency can be checked.
    task automatic send_packet(input logic [PKT_BITS-1:0] p, input int smin, input int smax,
                               input bit ready_last, input int gap_at);
        for (int i = PKT_BITS - 1; i > 0; i--)
            send_bit(p[i], (i == gap_at) ? TIMEOUT : $urandom_range(smax, smin));
        if (ready_last) pkt_ready = 1'b1;
        cycle(1'b1, p[0]);
        if (ready_last) pkt_ready = 1'b0;
    endtask

    task automatic drain();
        pkt_ready = 1'b1;
        cycle(1'b0, 1'b0);
        pkt_ready = 1'b0;
        cycle(1'b0, 1'b0);
    endtask

    function automatic logic [PKT_BITS-1:0] rand_pkt();
        logic [PKT_BITS-1:0] p;
        p = '0;
        p[PKT_BITS-1 -: 16] = HEADER;
        for (int i = 0; i < PKT_BITS - 16; i++) p[i] = 1'($urandom_range(1, 0));
        return p;
    endfunction

    logic [PKT_BITS-1:0] tp, p1, p2, p3;
    int                  hdr_before, err_before, drop_before;
    logic [4:0]          garbage;

    initial begin
        reset_n   = 1'b0;
        bit_tick  = 1'b0;
        data_in   = 1'b0;
        pkt_ready = 1'b0;
        model_reset();
        #13;
        check("rst_valid", pkt_valid, 0);
        check("rst_data", pkt_data, 0);
        check("rst_hdr", hdr_seen, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_drop", drop_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Test packet: header then bytes 0x01..0x2D.
        tp = '0;
        tp[PKT_BITS-1 -: 16] = HEADER;
        for (int k = 0; k < PKT_BYTES - 2; k++) tp[(PKT_BYTES - 3 - k) * 8 +: 8] = 8'(k + 1);

        // 1: tick every 24 clocks; valid one clock after the last tick.
        repeat (3) cycle(1'b0, 1'b0);
        send_packet(tp, 24, 24, 1'b0, -1);
        check("t1_valid", pkt_valid, 1);
        check("t1_hdr_bits", pkt_data[PKT_BITS-1 -: 16], 16'h542C);
        check("t1_last_byte", pkt_data[7:0], 8'h2D);
        check("t1_data", pkt_data, tp);
        check("t1_hdr_pulses", dut_hdr_pulses, 1);
        repeat (3) cycle(1'b0, 1'b0);
        drain();

        // 2: garbage 10101 ahead of the same packet.
        hdr_before = dut_hdr_pulses;
        garbage = 5'b10101;
        for (int i = 4; i >= 0; i--) send_bit(garbage[i], 3);
        send_packet(tp, 2, 6, 1'b0, -1);
        check("t2_data", pkt_data, tp);
        check("t2_hdr_pulses", dut_hdr_pulses, hdr_before + 1);
        drain();

        // 3: two packets with no consumer; second is dropped.
        p1 = rand_pkt();
        p2 = rand_pkt();
        send_packet(p1, 2, 6, 1'b0, -1);
        send_packet(p2, 2, 6, 1'b0, -1);
        repeat (2) cycle(1'b0, 1'b0);
        check("t3_data", pkt_data, p1);
        check("t3_drop", drop_cnt, 1);
        check("t3_valid", pkt_valid, 1);
        pkt_ready = 1'b1;
        cycle(1'b0, 1'b0);
        pkt_ready = 1'b0;
        check("t3_consumed", pkt_valid, 0);

        // 4: ready coincides with capture of packet 2; no drop.
        drop_before = int'(drop_cnt);
        p1 = rand_pkt();
        p2 = rand_pkt();
        send_packet(p1, 2, 6, 1'b0, -1);
        send_packet(p2, 2, 6, 1'b1, -1);
        check("t4_valid", pkt_valid, 1);
        check("t4_data", pkt_data, p2);
        check("t4_drop", drop_cnt, drop_before);
        drain();

        // 5: header + 10 bytes, then silence; then a packet with one gap of exactly TIMEOUT clocks.
        err_before = dut_err_pulses;
        p1 = rand_pkt();
        for (int i = PKT_BITS - 1; i >= PKT_BITS - 96; i--) send_bit(p1[i], $urandom_range(6, 2));
        repeat (TIMEOUT + 5) cycle(1'b0, 1'b0);
        check("t5_ferr_pulses", dut_err_pulses, err_before + 1);
        check("t5_no_valid", pkt_valid, 0);
        p2 = rand_pkt();
        send_packet(p2, 2, 6, 1'b0, 200);
        check("t5_valid", pkt_valid, 1);
        check("t5_data", pkt_data, p2);
        check("t5_gap_no_abort", dut_err_pulses, err_before + 1);
        drain();

        // 6: reset mid-COLLECT while a packet is buffered.
        p1 = rand_pkt();
        send_packet(p1, 2, 6, 1'b0, -1);
        p2 = rand_pkt();
        for (int i = PKT_BITS - 1; i >= PKT_BITS / 2; i--) send_bit(p2[i], $urandom_range(6, 2));
        bit_tick = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("t6_valid", pkt_valid, 0);
        check("t6_data", pkt_data, 0);
        check("t6_hdr", hdr_seen, 0);
        check("t6_ferr", frame_err, 0);
        check("t6_drop", drop_cnt, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        p3 = rand_pkt();
        send_packet(p3, 2, 6, 1'b0, -1);
        check("t6_after_valid", pkt_valid, 1);
        check("t6_after_data", pkt_data, p3);
        drain();

        // Random phase: random garbage, payloads and consumer readiness.
        rand_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(20, 0)) send_bit(1'($urandom_range(1, 0)), $urandom_range(5, 2));
            send_packet(rand_pkt(), 2, 5, 1'b0, -1);
            repeat ($urandom_range(10, 1)) cycle(1'b0, 1'b0);
        end
        rand_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
